// File: rtl/lsu_seq_if.sv
// lsu_seq_if: request/response handshake and data-memory port of lsu_seq.
// slave is the LSU side; master is the requester plus memory side.
interface lsu_seq_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_adr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_fault;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output req_valid, req_write, req_funct3, req_adr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_req, mem_adr, mem_we, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_adr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_req, mem_adr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_seq.sv
// lsu_seq: sequential load/store unit, valid/ready request side, req/gnt/rvalid memory port.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two beats; otherwise misaligned accesses fault.
module lsu_seq #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic      clk,
  input logic      reset_n,
  lsu_seq_if.slave bus
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFS  = $clog2(NB);
  localparam bit          IS64 = (XLEN == 64);

  typedef logic [NB-1:0]   be_t;
  typedef logic [XLEN-1:0] xw_t;
  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

  state_t            state_q, state_d;
  logic              wr_q, uns_q, fault_q;
  logic [1:0]        sz_q;
  logic [ADDR_W-1:0] adr_q;
  logic [XLEN-1:0]   wdata_q, rd0_q;

  logic              accept;
  logic [1:0]        in_sz;
  logic [3:0]        in_nb;
  logic [OFS-1:0]    in_o;
  logic              in_legal, in_fault;

  logic [OFS-1:0]    o;
  logic [3:0]        nbytes;
  logic [ADDR_W-1:0] base;
  be_t               be0;
  logic [XLEN-1:0]   wd0, raw, mask, msb, ext;

`ifdef LSU_MISALIGNED_EN
  typedef logic [2*NB-1:0]   be2_t;
  typedef logic [2*XLEN-1:0] dw_t;
  logic              cross_q, in_cross;
  logic [XLEN-1:0]   rd1_q, wd1;
  be_t               be1;
  be2_t              be_w;
  dw_t               wd_w;
`else
  logic              in_misal;
`endif

  assign accept = reset_n && bus.req_valid && (state_q == IDLE);

  // Decode straight from the request so a faulting access can skip the memory beats.
  always_comb begin
    in_sz = bus.req_funct3[1:0];
    in_nb = 4'd1 << in_sz;
    in_o  = bus.req_adr[OFS-1:0];
    if (bus.req_write)
      in_legal = !bus.req_funct3[2] && (IS64 || in_sz != 2'd3);
    else
      in_legal = (bus.req_funct3 != 3'b111) &&
                 (IS64 || (bus.req_funct3 != 3'b011 && bus.req_funct3 != 3'b110));
`ifdef LSU_MISALIGNED_EN
    in_cross = (5'(in_o) + 5'(in_nb)) > 5'(NB);
    in_fault = !in_legal;
`else
    in_misal = (4'(in_o) & (in_nb - 4'd1)) != 4'd0;
    in_fault = !in_legal || in_misal;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= bus.req_write;
      sz_q    <= in_sz;
      uns_q   <= bus.req_funct3[2];
      fault_q <= in_fault;
      adr_q   <= bus.req_adr;
      wdata_q <= bus.req_wdata;
`ifdef LSU_MISALIGNED_EN
      cross_q <= in_cross;
`endif
    end
    if (state_q == WAIT0 && bus.mem_rvalid && !wr_q) rd0_q <= bus.mem_rdata;
`ifdef LSU_MISALIGNED_EN
    if (state_q == WAIT1 && bus.mem_rvalid && !wr_q) rd1_q <= bus.mem_rdata;
`endif
  end

  // Lane placement; the double-width forms carry the spill-over into the second word.
  always_comb begin
    o      = adr_q[OFS-1:0];
    nbytes = 4'd1 << sz_q;
    base   = {adr_q[ADDR_W-1:OFS], {OFS{1'b0}}};
`ifdef LSU_MISALIGNED_EN
    be_w = ((be2_t'(1) << nbytes) - be2_t'(1)) << o;
    wd_w = dw_t'(wdata_q) << {o, 3'b000};
    be0  = be_w[NB-1:0];
    be1  = be_w[2*NB-1:NB];
    wd0  = wd_w[XLEN-1:0];
    wd1  = wd_w[2*XLEN-1:XLEN];
    raw  = xw_t'({rd1_q, rd0_q} >> {o, 3'b000});
`else
    be0  = ((be_t'(1) << nbytes) - be_t'(1)) << o;
    wd0  = wdata_q << {o, 3'b000};
    raw  = rd0_q >> {o, 3'b000};
`endif
    mask = (xw_t'(1) << {nbytes, 3'b000}) - xw_t'(1);
    msb  = mask & ~(mask >> 1);
    ext  = (raw & mask) | ((!uns_q && |(raw & msb)) ? ~mask : '0);
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_fault  = 1'b0;
    bus.rsp_rdata  = '0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_adr    = '0;
    bus.mem_be     = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = in_fault ? RESP : BEAT0;
      end
      BEAT0: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = wr_q;
        bus.mem_adr   = base;
        bus.mem_be    = be0;
        bus.mem_wdata = wd0;
        if (bus.mem_gnt) state_d = WAIT0;
      end
      WAIT0: begin
`ifdef LSU_MISALIGNED_EN
        if (bus.mem_rvalid) state_d = cross_q ? BEAT1 : RESP;
`else
        if (bus.mem_rvalid) state_d = RESP;
`endif
      end
`ifdef LSU_MISALIGNED_EN
      BEAT1: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = wr_q;
        bus.mem_adr   = base + ADDR_W'(NB);
        bus.mem_be    = be1;
        bus.mem_wdata = wd1;
        if (bus.mem_gnt) state_d = WAIT1;
      end
      WAIT1: begin
        if (bus.mem_rvalid) state_d = RESP;
      end
`endif
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_fault = fault_q;
        bus.rsp_rdata = (fault_q || wr_q) ? '0 : ext;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: directed and random load/store traffic against a byte-array reference model.
// Honours LSU_MISALIGNED_EN the same way the design does.
module tb_lsu_seq;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 32;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lsu_seq_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();
  lsu_seq #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  int gnt_wait = 0;
  int rv_wait  = 0;
  beat_t beat_log[$];
  logic [7:0] ref_mem [0:1023];
  logic [7:0] dut_mem [0:1023];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      ref_mem[a+i] = v[8*i +: 8];
      dut_mem[a+i] = v[8*i +: 8];
    end
  endtask

  // Memory: grant after gnt_wait cycles, complete rv_wait cycles after the grant cycle.
  initial begin
    beat_t b;
    int    a;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    @(posedge clk); #1;
    forever begin
      if (bus.mem_req === 1'b1) begin
        b.adr = bus.mem_adr; b.we = bus.mem_we; b.be = bus.mem_be; b.wdata = bus.mem_wdata;
        for (int i = 0; i < gnt_wait; i++) begin
          @(posedge clk); #1;
          check("stable_req", bus.mem_req, 1);
          check("stable_adr", bus.mem_adr, b.adr);
          check("stable_we", bus.mem_we, b.we);
          check("stable_be", bus.mem_be, b.be);
          check("stable_wdata", bus.mem_wdata, b.wdata);
        end
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        beat_log.push_back(b);
        for (int i = 0; i < rv_wait; i++) begin @(posedge clk); #1; end
        a = int'(b.adr[9:0]);
        for (int j = 0; j < 4; j++) begin
          if (b.we && b.be[j]) dut_mem[a+j] = b.wdata[8*j +: 8];
          bus.mem_rdata[8*j +: 8] = dut_mem[a+j];
        end
        bus.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  task automatic ref_model(input logic wr, input logic [2:0] f3, input logic [31:0] adr,
                           input logic [31:0] wd, output logic [31:0] exp_rd,
                           output logic exp_fault, output int exp_beats);
    int s;
    bit legal;
    logic [63:0] v;
    s = 1 << f3[1:0];
    legal = wr ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    exp_fault = !legal;
`ifndef LSU_MISALIGNED_EN
    if (adr % s != 0) exp_fault = 1'b1;
`endif
    exp_rd = '0;
    exp_beats = 0;
    if (!exp_fault) begin
      exp_beats = (int'(adr % 4) + s > 4) ? 2 : 1;
      if (wr) begin
        for (int i = 0; i < s; i++) ref_mem[adr+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[adr+i];
        if (!f3[2] && s < 4 && v[8*s-1]) for (int i = 8*s; i < 32; i++) v[i] = 1'b1;
        exp_rd = v[31:0];
      end
    end
  endtask

  // Starts and ends at posedge+1; lat counts clock periods after the accept period.
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] adr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic f,
                         output int lat);
    beat_log.delete();
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
    bus.req_adr = adr; bus.req_wdata = wd;
    check("req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_write = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_adr = $urandom; bus.req_wdata = $urandom;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.rsp_valid !== 1'b1) check("rsp_timeout", 0, 1);
    rd = bus.rsp_rdata;
    f  = bus.rsp_fault;
    @(posedge clk); #1;
    check("rsp_pulse", bus.rsp_valid, 0);
    check("ready_after", bus.req_ready, 1);
  endtask

  task automatic txn(input string name, input logic wr, input logic [2:0] f3,
                     input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] erd, rd;
    logic ef, f;
    int eb, lat, elat, a;
    logic [63:0] wr_ref, wr_dut;
    ref_model(wr, f3, adr, wd, erd, ef, eb);
    run_req(wr, f3, adr, wd, rd, f, lat);
    elat = ef ? 1 : 1 + eb * (2 + gnt_wait + rv_wait);
    check({name, "_fault"}, f, ef);
    check({name, "_rdata"}, rd, erd);
    check({name, "_latency"}, lat, elat);
    check({name, "_beats"}, beat_log.size(), eb);
    foreach (beat_log[i]) begin
      check({name, "_beat_adr"}, beat_log[i].adr, (adr & 32'hFFFF_FFFC) + 32'(4*i));
      check({name, "_beat_we"}, beat_log[i].we, wr);
    end
    if (wr) begin
      a = int'(adr[9:0]) & ~3;
      for (int i = 0; i < 8; i++) begin
        wr_ref[8*i +: 8] = ref_mem[a+i];
        wr_dut[8*i +: 8] = dut_mem[a+i];
      end
      check({name, "_memory"}, wr_dut, wr_ref);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    logic [31:0] radr;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
    bus.req_adr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 8'($urandom);
      dut_mem[i] = ref_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_fault", bus.rsp_fault, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_adr", bus.mem_adr, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // lb from the top byte lane, sign-extended
    set_word(32'h100, 32'h80FF_1234);
    txn("lb103", 1'b0, 3'b000, 32'h103, 32'h0);
    check("lb103_value", bus.rsp_rdata, 0);

    // sh into the upper half-word
    txn("sh102", 1'b1, 3'b001, 32'h102, 32'h0000_ABCD);
    if (beat_log.size() >= 1) begin
      check("sh102_be", beat_log[0].be, 4'b1100);
      check("sh102_wdata", beat_log[0].wdata, 32'hABCD_0000);
      check("sh102_we", beat_log[0].we, 1);
    end

    // lw crossing a word boundary
    set_word(32'h0FC, 32'h1122_3344);
    set_word(32'h100, 32'h5566_7788);
    txn("lw0fe", 1'b0, 3'b010, 32'h0FE, 32'h0);
`ifdef LSU_MISALIGNED_EN
    if (beat_log.size() >= 2) begin
      check("lw0fe_be0", beat_log[0].be, 4'b1100);
      check("lw0fe_be1", beat_log[1].be, 4'b0011);
    end
`endif

    // lhu at an odd address
    txn("lhu201", 1'b0, 3'b101, 32'h201, 32'h0);

    // funct3 011 is illegal at XLEN=32 for loads and stores
    txn("ld_illegal", 1'b0, 3'b011, 32'h108, 32'h0);
    txn("sd_illegal", 1'b1, 3'b011, 32'h108, 32'hDEAD_BEEF);
    txn("sbu_illegal", 1'b1, 3'b100, 32'h108, 32'hDEAD_BEEF);

    // grant withheld for five cycles
    gnt_wait = 5;
    txn("lw_gnt_hold", 1'b0, 3'b010, 32'h104, 32'h0);
    txn("sw_gnt_hold", 1'b1, 3'b010, 32'h10C, 32'hCAFE_F00D);
    gnt_wait = 0;

    // reset while waiting for rvalid
    rv_wait = 3;
    beat_log.delete();
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_adr = 32'h110; bus.req_wdata = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (beat_log.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
    check("abort_granted", beat_log.size(), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_ready", bus.req_ready, 1);
    check("abort_mem_req", bus.mem_req, 0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_rsp", bus.rsp_valid, 0);
      @(posedge clk); #1;
    end
    rv_wait = 0;
    txn("after_abort", 1'b0, 3'b010, 32'h110, 32'h0);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      radr = 32'($urandom_range(0, 1000));
      if ($urandom_range(0, 1) == 0) radr = radr & 32'hFFFF_FFFC;
      gnt_wait = $urandom_range(0, 2);
      rv_wait  = $urandom_range(0, 2);
      txn("rand", 1'($urandom), 3'($urandom), radr, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
